// File: rtl/codeword_packer_pkg.sv
// Shared definitions for the codeword packer: default widths, FSM state encoding
// and accumulator/fill width derivation used by the packer and its aligner.
package codeword_packer_pkg;

  // Default maximum codeword length, shared with the codebook selection logic.
  localparam int ENCODE_DATALENGTH_DEF = 21;
  localparam int OUT_WIDTH_DEF         = 32;

  localparam logic [1:0] PACK  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  function automatic int acc_width(input int encode_datalength, input int out_width);
    return encode_datalength + out_width;
  endfunction

  function automatic int fill_width(input int acc_w);
    return $clog2(acc_w + 1);
  endfunction

endpackage

// File: rtl/codeword_align.sv
// Combinational codeword aligner: clips the length, masks unused data bits and
// shifts the codeword to sit directly below the already-filled accumulator bits.
module codeword_align
  import codeword_packer_pkg::*;
#(
  parameter int ENCODE_DATALENGTH = ENCODE_DATALENGTH_DEF,
  parameter int OUT_WIDTH         = OUT_WIDTH_DEF,
  localparam int ACC_W            = acc_width(ENCODE_DATALENGTH, OUT_WIDTH),
  localparam int FILL_W           = fill_width(ACC_W)
) (
  input  logic [5:0]                   cw_length_i,
  input  logic [ENCODE_DATALENGTH-1:0] cw_data_i,
  input  logic [FILL_W-1:0]            fill_i,
  output logic [5:0]                   len_o,
  output logic [ACC_W-1:0]             placed_o
);

  localparam logic [5:0] LEN_MAX = 6'(ENCODE_DATALENGTH);

  logic [ENCODE_DATALENGTH-1:0] masked;
  logic [ACC_W-1:0]             ext;

  always_comb begin
    len_o = (cw_length_i > LEN_MAX) ? LEN_MAX : cw_length_i;

    masked = '0;
    for (int i = 0; i < ENCODE_DATALENGTH; i++) begin
      masked[i] = cw_data_i[i] & (i < int'(len_o));
    end

    // Left-align the codeword in the accumulator, then slide it below the filled bits.
    ext      = {masked, {OUT_WIDTH{1'b0}}};
    placed_o = (ext << (LEN_MAX - len_o)) >> fill_i;
  end

endmodule

// File: rtl/codeword_packer.sv
// Packs variable-length codewords MSB-first into fixed OUT_WIDTH-bit words, with
// zero-padded flush. Optional bit counter port enabled by CODEWORD_PACKER_STATS_EN.
module codeword_packer
  import codeword_packer_pkg::*;
#(
  parameter int ENCODE_DATALENGTH = ENCODE_DATALENGTH_DEF,
  parameter int OUT_WIDTH         = OUT_WIDTH_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cw_valid_i,
  output logic                         cw_ready_o,
  input  logic [5:0]                   cw_length_i,
  input  logic [ENCODE_DATALENGTH-1:0] cw_data_i,
  input  logic                         flush_i,
  output logic                         flush_done_o,
  output logic                         word_valid_o,
  input  logic                         word_ready_i,
  output logic [OUT_WIDTH-1:0]         word_data_o
`ifdef CODEWORD_PACKER_STATS_EN
  ,
  output logic [31:0]                  bit_count_o
`endif
);

  localparam int ACC_W  = acc_width(ENCODE_DATALENGTH, OUT_WIDTH);
  localparam int FILL_W = fill_width(ACC_W);
  localparam logic [FILL_W-1:0] OW_F = FILL_W'(OUT_WIDTH);

  logic [1:0]           state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [OUT_WIDTH-1:0] word_q, word_d;
  logic                 word_valid_q, word_valid_d;
  logic                 flush_done_q, flush_done_d;

  logic [5:0]           len;
  logic [ACC_W-1:0]     placed;
  logic                 accept;
  logic                 slot_free;

`ifdef CODEWORD_PACKER_STATS_EN
  logic [31:0]          bit_count_q, bit_count_d;
  assign bit_count_o = bit_count_q;
`endif

  codeword_align #(
    .ENCODE_DATALENGTH (ENCODE_DATALENGTH),
    .OUT_WIDTH         (OUT_WIDTH)
  ) u_align (
    .cw_length_i (cw_length_i),
    .cw_data_i   (cw_data_i),
    .fill_i      (fill_q),
    .len_o       (len),
    .placed_o    (placed)
  );

  assign cw_ready_o   = (state_q == PACK) && (fill_q < OW_F);
  assign accept       = cw_valid_i && cw_ready_o;
  assign slot_free    = !word_valid_q || word_ready_i;
  assign word_valid_o = word_valid_q;
  assign word_data_o  = word_q;
  assign flush_done_o = flush_done_q;

  always_comb begin
    // NOTE: every next-state value starts from its register so no path leaves it unassigned (no latch).
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    flush_done_d = 1'b0;
`ifdef CODEWORD_PACKER_STATS_EN
    bit_count_d  = bit_count_q;
`endif

    if (word_valid_q && word_ready_i) begin
      word_valid_d = 1'b0;
    end

    // Bits below fill are always zero, so OR-ing the placed codeword is safe.
    if (accept) begin
      acc_d  = acc_q | placed;
      fill_d = fill_q + FILL_W'(len);
`ifdef CODEWORD_PACKER_STATS_EN
      bit_count_d = bit_count_q + 32'(len);
`endif
    end else if (fill_q >= OW_F && slot_free) begin
      word_d       = acc_q[ACC_W-1 -: OUT_WIDTH];
      word_valid_d = 1'b1;
      acc_d        = acc_q << OUT_WIDTH;
      fill_d       = fill_q - OW_F;
    end else if (state_q == FLUSH && fill_q != '0 && slot_free) begin
      word_d       = acc_q[ACC_W-1 -: OUT_WIDTH];
      word_valid_d = 1'b1;
      acc_d        = '0;
      fill_d       = '0;
`ifdef CODEWORD_PACKER_STATS_EN
      bit_count_d = bit_count_q + 32'(OW_F - fill_q);
`endif
    end

    case (state_q)
      PACK: begin
        if (flush_i) state_d = FLUSH;
      end
      FLUSH: begin
        if (fill_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
        if (!word_valid_q) begin
          flush_done_d = 1'b1;
          state_d      = PACK;
        end
      end
      default: state_d = PACK;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= PACK;
      acc_q        <= '0;
      fill_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      flush_done_q <= 1'b0;
`ifdef CODEWORD_PACKER_STATS_EN
      bit_count_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      flush_done_q <= flush_done_d;
`ifdef CODEWORD_PACKER_STATS_EN
      bit_count_q  <= bit_count_d;
`endif
    end
  end

endmodule
